// File: rtl/uart_serial_bridge.sv
// uart_serial_bridge: byte-wide 8N1 UART bridge between a processor serial
// port and a pair of UART pins. RX path is a 2-flop synchronizer, a sampling
// FSM and a first-word-fall-through RX FIFO; TX path is a first-word-fall-
// through TX FIFO drained by a serializing FSM.
// Optional feature macro: UART_BRIDGE_PARITY_EN adds an even-parity bit to
// both directions and the sticky parity_err_out port.
module uart_serial_bridge #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW      = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic [7:0] rx_data_out,
  output logic       rx_valid_out,
  input  logic       rx_rden_in,
  input  logic [7:0] tx_data_in,
  input  logic       tx_wren_in,
  output logic       tx_ready_out,
  input  logic       status_clr_in,
  output logic       overrun_out,
  output logic       frame_err_out
`ifdef UART_BRIDGE_PARITY_EN
  ,
  output logic       parity_err_out
`endif
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

  // ---------------------------------------------------------------- RX FIFO
  logic [7:0]       rx_mem_r [DEPTH];
  logic [FIFO_AW:0] rx_wptr_r;
  logic [FIFO_AW:0] rx_rptr_r;
  logic             rx_empty_s;
  logic             rx_full_s;
  logic             rx_pop_ok_s;
  logic             rx_push_s;
  logic             rx_push_ok_s;
  logic             ovr_set_s;
  logic [7:0]       rx_shift_r;

  assign rx_empty_s   = (rx_wptr_r == rx_rptr_r);
  assign rx_full_s    = (rx_wptr_r[FIFO_AW] != rx_rptr_r[FIFO_AW]) &&
                        (rx_wptr_r[FIFO_AW-1:0] == rx_rptr_r[FIFO_AW-1:0]);
  assign rx_pop_ok_s  = rx_rden_in && !rx_empty_s;
  // A pop in the same cycle frees the slot needed by a push into a full FIFO.
  assign rx_push_ok_s = rx_push_s && (!rx_full_s || rx_pop_ok_s);
  assign ovr_set_s    = rx_push_s && rx_full_s && !rx_pop_ok_s;
  assign rx_data_out  = rx_mem_r[rx_rptr_r[FIFO_AW-1:0]];
  assign rx_valid_out = !rx_empty_s;

  // RX FIFO storage: written on an accepted push; contents need no reset.
  always_ff @(posedge clock) begin
    if (rx_push_ok_s) begin
      rx_mem_r[rx_wptr_r[FIFO_AW-1:0]] <= rx_shift_r;
    end
  end

  // RX FIFO pointers advance on accepted push/pop and clear on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_wptr_r <= {(FIFO_AW+1){1'b0}};
      rx_rptr_r <= {(FIFO_AW+1){1'b0}};
    end else begin
      if (rx_push_ok_s) rx_wptr_r <= rx_wptr_r + {{FIFO_AW{1'b0}}, 1'b1};
      if (rx_pop_ok_s)  rx_rptr_r <= rx_rptr_r + {{FIFO_AW{1'b0}}, 1'b1};
    end
  end

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]       tx_mem_r [DEPTH];
  logic [FIFO_AW:0] tx_wptr_r;
  logic [FIFO_AW:0] tx_rptr_r;
  logic             tx_empty_s;
  logic             tx_full_s;
  logic             tx_pop_s;
  logic             tx_push_ok_s;
  logic [7:0]       tx_head_s;

  assign tx_empty_s   = (tx_wptr_r == tx_rptr_r);
  assign tx_full_s    = (tx_wptr_r[FIFO_AW] != tx_rptr_r[FIFO_AW]) &&
                        (tx_wptr_r[FIFO_AW-1:0] == tx_rptr_r[FIFO_AW-1:0]);
  // tx_pop_s is only raised by the serializer when the FIFO is non-empty.
  assign tx_push_ok_s = tx_wren_in && (!tx_full_s || tx_pop_s);
  assign tx_head_s    = tx_mem_r[tx_rptr_r[FIFO_AW-1:0]];
  assign tx_ready_out = !tx_full_s;

  // TX FIFO storage: written on an accepted push; contents need no reset.
  always_ff @(posedge clock) begin
    if (tx_push_ok_s) begin
      tx_mem_r[tx_wptr_r[FIFO_AW-1:0]] <= tx_data_in;
    end
  end

  // TX FIFO pointers advance on accepted push/pop and clear on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_wptr_r <= {(FIFO_AW+1){1'b0}};
      tx_rptr_r <= {(FIFO_AW+1){1'b0}};
    end else begin
      if (tx_push_ok_s) tx_wptr_r <= tx_wptr_r + {{FIFO_AW{1'b0}}, 1'b1};
      if (tx_pop_s)     tx_rptr_r <= tx_rptr_r + {{FIFO_AW{1'b0}}, 1'b1};
    end
  end

  // ---------------------------------------------------------------- TX FSM
  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_STOP   = 3'd3
`ifdef UART_BRIDGE_PARITY_EN
    ,
    TX_PARITY = 3'd4
`endif
  } tx_state_t;

  tx_state_t     tx_state_r, tx_state_nxt_s;
  logic [CW-1:0] tx_cnt_r, tx_cnt_nxt_s;
  logic [2:0]    tx_bit_r, tx_bit_nxt_s;
  logic [2:0]    tx_bit_inc_s;
  logic [7:0]    tx_byte_r, tx_byte_nxt_s;
  logic          tx_line_r, tx_line_nxt_s;
  logic          tx_last_s;

  assign tx_last_s    = (tx_cnt_r == CNT_LAST);
  assign tx_bit_inc_s = tx_bit_r + 3'd1;
  assign uart_tx      = tx_line_r;

  // TX state register; the line is registered so it idles high right after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state_r <= TX_IDLE;
      tx_cnt_r   <= CNT_ZERO;
      tx_bit_r   <= 3'd0;
      tx_byte_r  <= 8'h00;
      tx_line_r  <= 1'b1;
    end else begin
      tx_state_r <= tx_state_nxt_s;
      tx_cnt_r   <= tx_cnt_nxt_s;
      tx_bit_r   <= tx_bit_nxt_s;
      tx_byte_r  <= tx_byte_nxt_s;
      tx_line_r  <= tx_line_nxt_s;
    end
  end

  // TX next-state: each bit lasts CLKS_PER_BIT cycles; a new byte is fetched
  // at the end of a stop bit so back-to-back frames have no idle gap.
  always_comb begin
    tx_state_nxt_s = tx_state_r;
    tx_cnt_nxt_s   = tx_cnt_r + CNT_ONE;
    tx_bit_nxt_s   = tx_bit_r;
    tx_byte_nxt_s  = tx_byte_r;
    tx_line_nxt_s  = tx_line_r;
    tx_pop_s       = 1'b0;
    case (tx_state_r)
      TX_IDLE: begin
        tx_cnt_nxt_s  = CNT_ZERO;
        tx_line_nxt_s = 1'b1;
        if (!tx_empty_s) begin
          tx_pop_s       = 1'b1;
          tx_byte_nxt_s  = tx_head_s;
          tx_state_nxt_s = TX_START;
          tx_line_nxt_s  = 1'b0;
        end else begin
          tx_state_nxt_s = TX_IDLE;
        end
      end
      TX_START: begin
        if (tx_last_s) begin
          tx_cnt_nxt_s   = CNT_ZERO;
          tx_bit_nxt_s   = 3'd0;
          tx_state_nxt_s = TX_DATA;
          tx_line_nxt_s  = tx_byte_r[0];
        end else begin
          tx_state_nxt_s = TX_START;
        end
      end
      TX_DATA: begin
        if (tx_last_s) begin
          tx_cnt_nxt_s = CNT_ZERO;
          if (tx_bit_r == 3'd7) begin
`ifdef UART_BRIDGE_PARITY_EN
            tx_state_nxt_s = TX_PARITY;
            tx_line_nxt_s  = even_parity(tx_byte_r);
`else
            tx_state_nxt_s = TX_STOP;
            tx_line_nxt_s  = 1'b1;
`endif
          end else begin
            tx_bit_nxt_s  = tx_bit_inc_s;
            tx_line_nxt_s = tx_byte_r[tx_bit_inc_s];
          end
        end else begin
          tx_state_nxt_s = TX_DATA;
        end
      end
`ifdef UART_BRIDGE_PARITY_EN
      TX_PARITY: begin
        if (tx_last_s) begin
          tx_cnt_nxt_s   = CNT_ZERO;
          tx_state_nxt_s = TX_STOP;
          tx_line_nxt_s  = 1'b1;
        end else begin
          tx_state_nxt_s = TX_PARITY;
        end
      end
`endif
      TX_STOP: begin
        if (tx_last_s) begin
          tx_cnt_nxt_s = CNT_ZERO;
          if (!tx_empty_s) begin
            tx_pop_s       = 1'b1;
            tx_byte_nxt_s  = tx_head_s;
            tx_state_nxt_s = TX_START;
            tx_line_nxt_s  = 1'b0;
          end else begin
            tx_state_nxt_s = TX_IDLE;
            tx_line_nxt_s  = 1'b1;
          end
        end else begin
          tx_state_nxt_s = TX_STOP;
        end
      end
      default: begin
        tx_state_nxt_s = TX_IDLE;
        tx_cnt_nxt_s   = CNT_ZERO;
        tx_line_nxt_s  = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------- RX path
  logic rx_meta_r;
  logic rx_sync_r;

  // Two-flop synchronizer for the asynchronous line; resets to the idle level.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= uart_rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_STOP   = 3'd3
`ifdef UART_BRIDGE_PARITY_EN
    ,
    RX_PARITY = 3'd4
`endif
  } rx_state_t;

  rx_state_t     rx_state_r, rx_state_nxt_s;
  logic [CW-1:0] rx_cnt_r, rx_cnt_nxt_s;
  logic [2:0]    rx_bit_r, rx_bit_nxt_s;
  logic [7:0]    rx_shift_nxt_s;
  logic          rx_brk_r, rx_brk_nxt_s;
  logic          rx_last_s;
  logic          fe_set_s;
`ifdef UART_BRIDGE_PARITY_EN
  logic          rx_par_bad_r, rx_par_bad_nxt_s;
  logic          pe_set_s;
`endif

  assign rx_last_s = (rx_cnt_r == CNT_LAST);

  // RX state register; a frame in progress at reset is abandoned.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state_r   <= RX_IDLE;
      rx_cnt_r     <= CNT_ZERO;
      rx_bit_r     <= 3'd0;
      rx_shift_r   <= 8'h00;
      rx_brk_r     <= 1'b0;
`ifdef UART_BRIDGE_PARITY_EN
      rx_par_bad_r <= 1'b0;
`endif
    end else begin
      rx_state_r   <= rx_state_nxt_s;
      rx_cnt_r     <= rx_cnt_nxt_s;
      rx_bit_r     <= rx_bit_nxt_s;
      rx_shift_r   <= rx_shift_nxt_s;
      rx_brk_r     <= rx_brk_nxt_s;
`ifdef UART_BRIDGE_PARITY_EN
      rx_par_bad_r <= rx_par_bad_nxt_s;
`endif
    end
  end

  // RX next-state: sample the start bit at mid-bit, then every bit period;
  // after a bad stop bit hold in STOP until the line returns high.
  always_comb begin
    rx_state_nxt_s   = rx_state_r;
    rx_cnt_nxt_s     = rx_cnt_r + CNT_ONE;
    rx_bit_nxt_s     = rx_bit_r;
    rx_shift_nxt_s   = rx_shift_r;
    rx_brk_nxt_s     = rx_brk_r;
    rx_push_s        = 1'b0;
    fe_set_s         = 1'b0;
`ifdef UART_BRIDGE_PARITY_EN
    rx_par_bad_nxt_s = rx_par_bad_r;
    pe_set_s         = 1'b0;
`endif
    case (rx_state_r)
      RX_IDLE: begin
        rx_cnt_nxt_s = CNT_ZERO;
        if (!rx_sync_r) begin
          rx_state_nxt_s = RX_START;
        end else begin
          rx_state_nxt_s = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_cnt_r == CNT_HALF) begin
          rx_cnt_nxt_s = CNT_ZERO;
          rx_bit_nxt_s = 3'd0;
          if (rx_sync_r) begin
            rx_state_nxt_s = RX_IDLE;
          end else begin
            rx_state_nxt_s = RX_DATA;
          end
        end else begin
          rx_state_nxt_s = RX_START;
        end
      end
      RX_DATA: begin
        if (rx_last_s) begin
          rx_cnt_nxt_s   = CNT_ZERO;
          rx_shift_nxt_s = {rx_sync_r, rx_shift_r[7:1]};
          if (rx_bit_r == 3'd7) begin
`ifdef UART_BRIDGE_PARITY_EN
            rx_state_nxt_s = RX_PARITY;
`else
            rx_state_nxt_s = RX_STOP;
`endif
          end else begin
            rx_bit_nxt_s = rx_bit_r + 3'd1;
          end
        end else begin
          rx_state_nxt_s = RX_DATA;
        end
      end
`ifdef UART_BRIDGE_PARITY_EN
      RX_PARITY: begin
        if (rx_last_s) begin
          rx_cnt_nxt_s     = CNT_ZERO;
          rx_state_nxt_s   = RX_STOP;
          rx_par_bad_nxt_s = (rx_sync_r != even_parity(rx_shift_r));
          pe_set_s         = (rx_sync_r != even_parity(rx_shift_r));
        end else begin
          rx_state_nxt_s = RX_PARITY;
        end
      end
`endif
      RX_STOP: begin
        if (rx_brk_r) begin
          rx_cnt_nxt_s = CNT_ZERO;
          if (rx_sync_r) begin
            rx_brk_nxt_s   = 1'b0;
            rx_state_nxt_s = RX_IDLE;
          end else begin
            rx_state_nxt_s = RX_STOP;
          end
        end else if (rx_last_s) begin
          rx_cnt_nxt_s = CNT_ZERO;
          if (rx_sync_r) begin
            rx_state_nxt_s = RX_IDLE;
`ifdef UART_BRIDGE_PARITY_EN
            rx_push_s      = !rx_par_bad_r;
`else
            rx_push_s      = 1'b1;
`endif
          end else begin
            fe_set_s       = 1'b1;
            rx_brk_nxt_s   = 1'b1;
            rx_state_nxt_s = RX_STOP;
          end
        end else begin
          rx_state_nxt_s = RX_STOP;
        end
      end
      default: begin
        rx_state_nxt_s = RX_IDLE;
        rx_cnt_nxt_s   = CNT_ZERO;
        rx_brk_nxt_s   = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------- status
  logic overrun_r;
  logic frame_err_r;
`ifdef UART_BRIDGE_PARITY_EN
  logic parity_err_r;
  assign parity_err_out = parity_err_r;
`endif
  assign overrun_out   = overrun_r;
  assign frame_err_out = frame_err_r;

  // Sticky error flags: a set in the same cycle as a clear wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      overrun_r    <= 1'b0;
      frame_err_r  <= 1'b0;
`ifdef UART_BRIDGE_PARITY_EN
      parity_err_r <= 1'b0;
`endif
    end else begin
      if (ovr_set_s)          overrun_r <= 1'b1;
      else if (status_clr_in) overrun_r <= 1'b0;
      if (fe_set_s)           frame_err_r <= 1'b1;
      else if (status_clr_in) frame_err_r <= 1'b0;
`ifdef UART_BRIDGE_PARITY_EN
      if (pe_set_s)           parity_err_r <= 1'b1;
      else if (status_clr_in) parity_err_r <= 1'b0;
`endif
    end
  end

endmodule
